regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter for the 32×32 register file's single write port. Two producers share the port: the ALU result path (requester 0) and the load/memory result path (requester 1). Each producer has a one-entry holding slot. The block grants round-robin, preserves program order for same-register writes, drops writes to r0, and publishes a pending-write mask for hazard detection. Its outputs drive the register file's `reg_write` / `Write_reg_number` / `Write_Data` inputs directly.

## Interface
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register index width (register count = 2^ADDR_W)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `req0_valid`  in  1  ALU write-back request
- `req0_addr`  in  ADDR_W  destination register
- `req0_data`  in  DATA_W  write data
- `req0_ready`  out  1  slot 0 can accept this cycle
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: same as above, for the load path
- `reg_write`  out  1  registered write strobe to the register file
- `Write_reg_number`  out  ADDR_W  registered write index
- `Write_Data`  out  DATA_W  registered write data
- `grant_id`  out  1  requester issued in the current cycle (valid while `issue_valid` = 1)
- `issue_valid`  out  1  a slot was drained at the last edge (high even for r0 drops)
- `pending_mask`  out  2^ADDR_W  bit k = a slot holds an unissued write to register k (bit 0 always 0)

## Operation
- State:
  - per slot: `full`, `addr`, `data`, `age` (1 = older of two full slots)
  - round-robin pointer `rr` (preferred requester)
  - output registers
- Grant is combinational from the registered slot state:
  - neither slot full: no grant
  - one slot full: grant it
  - both full, same addr: grant the slot with `age` = 1 (ordering rule overrides `rr`)
  - both full, different addr: grant `rr`
- `reqN_ready` = ~`fullN` | `grantN`, so a slot can drain and refill at the same edge.
- At each rising edge:
  - granted slot moves to the output registers; `issue_valid` = 1, `grant_id` = winner
  - `reg_write` = 1 only if the winner's addr ≠ 0; an r0 write is consumed silently with `reg_write` = 0
  - `Write_reg_number` / `Write_Data` load the winner's addr/data regardless
  - `rr` ← ~winner
  - if nothing is granted, `reg_write` = `issue_valid` = 0 and `rr` is unchanged
- Accept: `reqN_valid` & `reqN_ready` loads slot N.
- Age assignment:
  - slot loaded while the other slot stays full: new slot `age` = 0, other `age` = 1
  - both slots loaded at the same edge: slot 0 `age` = 1 (req0 is older, so req1's same-address write lands last)
  - only one slot full after the edge: its `age` = 1
- `pending_mask` = OR of decoded addr of each full slot, with bit 0 forced to 0; derived only from registered state.

## Timing
- Reset value of all outputs: 0 (`reg_write`, `Write_reg_number`, `Write_Data`, `grant_id`, `issue_valid`, `pending_mask`). `req0_ready` / `req1_ready` read 1 as soon as reset deasserts, because slots are empty.
- Latency:
  - request accepted at edge N is issued at edge N+1 at the earliest
  - `reg_write` is high for cycle N+1 → N+2, and the register file commits at the falling edge inside that cycle
- Throughput:
  - one write per cycle total
  - a lone requester sustains one per cycle
  - two continuously-valid requesters alternate, each seeing `ready` = 0 every other cycle
- Output registers change only at the rising edge, giving half a cycle of setup before the register file's falling-edge write.
- A register's `pending_mask` bit clears at the issue edge, i.e. in the same cycle in which `reg_write` is high. Readers see new data only after that cycle's falling edge.
- Reset mid-operation clears slots, `rr`, age and outputs asynchronously. Held writes are discarded, not issued.

## Test plan
- Reset, then `req0_valid` with addr 3, data 0x1234 for one cycle → `reg_write` = 1, `Write_reg_number` = 3, `Write_Data` = 0x1234 one cycle after acceptance; `pending_mask[3]` high for exactly one cycle.
- Both requesters valid every cycle (req0: addr 1, req1: addr 2) for 8 cycles → issues alternate 0,1,0,1…, starting with `grant_id` = 0; each `ready` toggles; no request is lost.
- Same edge, req0 addr 5 data 0xA and req1 addr 5 data 0xB → issue order is 0xA then 0xB; r5 in the register file finally holds 0xB.
- req1 addr 0 data 0xFF → `issue_valid` = 1, `grant_id` = 1, `reg_write` = 0; r0 unchanged; `pending_mask` = 0 throughout.
- Fill both slots, then assert `reset` low between edges → all outputs 0 immediately; after release, no write issues without new requests.
- req0 held continuously valid with incrementing addrs 1..6 → six consecutive cycles of `reg_write` = 1; `req0_ready` never drops.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: two one-entry
// holding slots, round-robin grant with same-register ordering, r0 drop, pending mask.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_valid,
  input  logic [ADDR_W-1:0]       req0_addr,
  input  logic [DATA_W-1:0]       req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [ADDR_W-1:0]       req1_addr,
  input  logic [DATA_W-1:0]       req1_data,
  output logic                    req1_ready,
  output logic                    reg_write,
  output logic [ADDR_W-1:0]       Write_reg_number,
  output logic [DATA_W-1:0]       Write_Data,
  output logic                    grant_id,
  output logic                    issue_valid,
  output logic [(2**ADDR_W)-1:0]  pending_mask
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic              r_full0, r_full1;
  logic              r_age0, r_age1;
  logic [ADDR_W-1:0] r_addr0, r_addr1;
  logic [DATA_W-1:0] r_data0, r_data1;
  logic              r_rr;

  logic              w_grant, w_win;
  logic              w_drain0, w_drain1;
  logic              w_acc0, w_acc1;
  logic              w_nfull0, w_nfull1;
  logic              w_nage0, w_nage1;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_data;
  logic [NREG-1:0]   w_dec0, w_dec1;

  // Grant from registered slot state; the older slot wins a same-register collision.
  always_comb begin
    w_grant = 1'b0;
    w_win   = 1'b0;
    if (r_full0 && r_full1) begin
      w_grant = 1'b1;
      w_win   = (r_addr0 == r_addr1) ? ~r_age0 : r_rr;
    end else if (r_full0) begin
      w_grant = 1'b1;
      w_win   = 1'b0;
    end else if (r_full1) begin
      w_grant = 1'b1;
      w_win   = 1'b1;
    end
  end

  assign w_drain0   = w_grant & ~w_win;
  assign w_drain1   = w_grant &  w_win;
  assign req0_ready = ~r_full0 | w_drain0;
  assign req1_ready = ~r_full1 | w_drain1;
  assign w_acc0     = req0_valid & req0_ready;
  assign w_acc1     = req1_valid & req1_ready;
  assign w_nfull0   = w_acc0 | (r_full0 & ~w_drain0);
  assign w_nfull1   = w_acc1 | (r_full1 & ~w_drain1);
  assign w_win_addr = w_win ? r_addr1 : r_addr0;
  assign w_win_data = w_win ? r_data1 : r_data0;

  // Age tracking: with both loaded together, req0 counts as older.
  always_comb begin
    w_nage0 = w_nfull0;
    w_nage1 = w_nfull1;
    if (w_nfull0 && w_nfull1) begin
      if (w_acc0 && w_acc1) begin
        w_nage0 = 1'b1;
        w_nage1 = 1'b0;
      end else if (w_acc0) begin
        w_nage0 = 1'b0;
        w_nage1 = 1'b1;
      end else if (w_acc1) begin
        w_nage0 = 1'b1;
        w_nage1 = 1'b0;
      end else begin
        w_nage0 = r_age0;
        w_nage1 = r_age1;
      end
    end
  end

  assign w_dec0       = r_full0 ? (NREG'(1) << r_addr0) : '0;
  assign w_dec1       = r_full1 ? (NREG'(1) << r_addr1) : '0;
  assign pending_mask = (w_dec0 | w_dec1) & ~NREG'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full0          <= 1'b0;
      r_full1          <= 1'b0;
      r_age0           <= 1'b0;
      r_age1           <= 1'b0;
      r_addr0          <= '0;
      r_addr1          <= '0;
      r_data0          <= '0;
      r_data1          <= '0;
      r_rr             <= 1'b0;
      reg_write        <= 1'b0;
      Write_reg_number <= '0;
      Write_Data       <= '0;
      grant_id         <= 1'b0;
      issue_valid      <= 1'b0;
    end else begin
      r_full0 <= w_nfull0;
      r_full1 <= w_nfull1;
      r_age0  <= w_nage0;
      r_age1  <= w_nage1;
      if (w_acc0) begin
        r_addr0 <= req0_addr;
        r_data0 <= req0_data;
      end
      if (w_acc1) begin
        r_addr1 <= req1_addr;
        r_data1 <= req1_data;
      end
      issue_valid <= w_grant;
      reg_write   <= w_grant && (w_win_addr != '0);
      if (w_grant) begin
        grant_id         <= w_win;
        Write_reg_number <= w_win_addr;
        Write_Data       <= w_win_data;
        r_rr             <= ~w_win;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed stimulus pushes hand-computed
// issues into a queue; a negedge monitor pops and compares each issued write.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;

  typedef struct packed {
    logic          gid;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic          reg_write, grant_id, issue_valid;
  logic [AW-1:0] Write_reg_number;
  logic [DW-1:0] Write_Data;
  logic [NR-1:0] pending_mask;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [DW-1:0] rf [NR] = '{default: '0};

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .reg_write(reg_write), .Write_reg_number(Write_reg_number), .Write_Data(Write_Data),
    .grant_id(grant_id), .issue_valid(issue_valid), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  // Register file model: commits on the falling edge inside the reg_write cycle.
  always @(negedge clk) begin
    if (reg_write && Write_reg_number != '0) rf[Write_reg_number] = Write_Data;
  end

  // Monitor: every issue must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e, a;
    if (reset && issue_valid) begin
      checks++;
      a.gid = grant_id; a.we = reg_write; a.addr = Write_reg_number; a.data = Write_Data;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected actual gid=%0d we=%0d addr=%0d data=0x%0h required none",
                 a.gid, a.we, a.addr, a.data);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL issue actual gid=%0d we=%0d addr=%0d data=0x%0h required gid=%0d we=%0d addr=%0d data=0x%0h",
                   a.gid, a.we, a.addr, a.data, e.gid, e.we, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic gid, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    e.gid = gid; e.we = we; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    logic f0, f1;
    logic [DW-1:0] d0, d1;

    // Reset values
    #2 reset = 1'b0;
    #1;
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_wnum", 64'(Write_reg_number), 64'd0);
    chk("rst_wdata", 64'(Write_Data), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_issue", 64'(issue_valid), 64'd0);
    chk("rst_pending", 64'(pending_mask), 64'd0);
    step(); step();
    reset = 1'b1;
    chk("rst_ready0", 64'(req0_ready), 64'd1);
    chk("rst_ready1", 64'(req1_ready), 64'd1);

    // Single ALU write to r3
    push(1'b0, 1'b1, 5'd3, 32'h1234);
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1234;
    step();
    req0_valid = 1'b0;
    chk("t1_pending_set", 64'(pending_mask), 64'h8);
    step();
    chk("t1_pending_clr", 64'(pending_mask), 64'd0);
    chk("t1_reg_write", 64'(reg_write), 64'd1);
    step();
    chk("t1_reg_write_off", 64'(reg_write), 64'd0);
    chk("t1_rf3", 64'(rf[3]), 64'h1234);

    // Both requesters continuously valid: alternation from reset
    do_reset();
    d0 = 32'h100; d1 = 32'h200;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 1'b1, 5'd1, 32'h100 + 32'(i));
      push(1'b1, 1'b1, 5'd2, 32'h200 + 32'(i));
    end
    push(1'b0, 1'b1, 5'd1, 32'h104);
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = d0;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = d1;
    chk("t2_ready0_c0", 64'(req0_ready), 64'd1);
    chk("t2_ready1_c0", 64'(req1_ready), 64'd1);
    for (int c = 1; c <= 8; c++) begin
      f0 = req0_ready; f1 = req1_ready;
      step();
      if (f0) d0 = d0 + 32'd1;
      if (f1) d1 = d1 + 32'd1;
      req0_data = d0; req1_data = d1;
      if (c <= 7) begin
        chk($sformatf("t2_ready0_c%0d", c), 64'(req0_ready), 64'(c % 2));
        chk($sformatf("t2_ready1_c%0d", c), 64'(req1_ready), 64'(1 - (c % 2)));
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) step();
    chk("t2_drained", 64'(exp_q.size()), 64'd0);

    // Same register from both producers at the same edge: A then B
    push(1'b0, 1'b1, 5'd5, 32'hA);
    push(1'b1, 1'b1, 5'd5, 32'hB);
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hA;
    req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'hB;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t3_pending", 64'(pending_mask), 64'h20);
    repeat (3) step();
    chk("t3_rf5", 64'(rf[5]), 64'hB);

    // Write to r0 is consumed without a strobe
    push(1'b1, 1'b0, 5'd0, 32'hFF);
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFF;
    step();
    req1_valid = 1'b0;
    chk("t4_pending_held", 64'(pending_mask), 64'd0);
    step();
    chk("t4_pending_issue", 64'(pending_mask), 64'd0);
    chk("t4_issue_valid", 64'(issue_valid), 64'd1);
    chk("t4_reg_write", 64'(reg_write), 64'd0);
    step();
    chk("t4_rf0", 64'(rf[0]), 64'd0);

    // Fill both slots, issue one, then reset mid-cycle: everything discarded
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
    req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h88;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t5_pending_full", 64'(pending_mask), 64'h180);
    step();
    #2 reset = 1'b0;
    #1;
    chk("t5_reg_write", 64'(reg_write), 64'd0);
    chk("t5_issue", 64'(issue_valid), 64'd0);
    chk("t5_wnum", 64'(Write_reg_number), 64'd0);
    chk("t5_wdata", 64'(Write_Data), 64'd0);
    chk("t5_gid", 64'(grant_id), 64'd0);
    chk("t5_pending", 64'(pending_mask), 64'd0);
    chk("t5_ready0", 64'(req0_ready), 64'd1);
    chk("t5_ready1", 64'(req1_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) step();
    chk("t5_no_issue", 64'(issue_valid), 64'd0);
    chk("t5_rf7", 64'(rf[7]), 64'd0);
    chk("t5_rf8", 64'(rf[8]), 64'd0);

    // Lone requester streams one write per cycle
    for (int i = 1; i <= 6; i++) push(1'b0, 1'b1, AW'(i), 32'h60 + 32'(i));
    for (int i = 1; i <= 6; i++) begin
      req0_valid = 1'b1; req0_addr = AW'(i); req0_data = 32'h60 + 32'(i);
      chk($sformatf("t6_ready0_%0d", i), 64'(req0_ready), 64'd1);
      step();
      if (i >= 2) chk($sformatf("t6_reg_write_%0d", i - 1), 64'(reg_write), 64'd1);
    end
    req0_valid = 1'b0;
    step();
    chk("t6_reg_write_6", 64'(reg_write), 64'd1);
    step();
    chk("t6_reg_write_off", 64'(reg_write), 64'd0);
    chk("t6_rf6", 64'(rf[6]), 64'h66);

    step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
